branch_hazard_ctrl: RTL and testbench
=====================================

// Module: branch_hazard_ctrl
// PURPOSE
//  ID-stage hazard/stall sequencer for the 5-stage MIPS pipeline with early branch resolution.
//  It detects RAW hazards for beq/bnq and load-use, and runs the stall FSM that freezes PC and IF/ID
//  and inserts ID/EX bubbles. It selects the ID comparator forwarding source (EX/MEM/WB)
//  and flushes IF/ID on a taken branch. A saturating stall counter is kept for performance checks.
// PARAMETERS
//  CNT_W    16   width of stall_cnt perf counter (saturates at 2**CNT_W-1)
// PORTS
//  clk           in   1      pipeline clock; all state updates on rising edge
//  rst_n         in   1      synchronous active-low reset
//  hold          in   1      global memory stall; freezes FSM, counter and all pipeline enables
//  beq, bnq      in   1      ID instruction is a branch (compare IDRs vs IDRt)
//  id_use_rs     in   1      ID instruction reads rs (ALU/load/store/branch)
//  id_use_rt     in   1      ID instruction reads rt
//  IDRs, IDRt    in   5      ID source register numbers
//  EXRd          in   5      EX-stage destination
//  EX_regwrite   in   1      EX instruction writes register file
//  EX_memread    in   1      EX instruction is a load
//  MEMRd         in   5      MEM-stage destination
//  MEM_regwrite  in   1      MEM instruction writes register file
//  MEM_memread   in   1      MEM instruction is a load
//  WBRd          in   5      WB-stage destination
//  WB_regwrite   in   1      WB instruction writes register file
//  branch_taken  in   1      ID comparator result (valid only when beq|bnq)
//  pc_write      out  1      PC register enable
//  ifid_write    out  1      IF/ID register enable
//  idex_bubble   out  1      zero ID/EX control fields this cycle
//  ifid_flush    out  1      squash IF/ID contents (taken branch)
//  forwardA      out  2      ID rs source: 00 regfile, 01 EX ALU, 11 EX/MEM ALU, 10 MEM/WB value
//  forwardB      out  2      ID rt source, same encoding
//  stall_cnt     out  CNT_W  total stall cycles since reset
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, rem=0, stall_cnt=0. Outputs while reset is held:
//   pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, forwardA/B=00.
//  A match(Rd,R) requires the writer's regwrite=1, Rd!=0 and Rd==R, with R enabled by id_use_*.
//  Hazard classes are evaluated in IDLE only, in priority order:
//   H2: branch, and EX_memread with match(EXRd) -> N=2 stall cycles.
//   H1: (branch, and match(EXRd) non-load or MEM_memread with match(MEMRd)), or (non-branch,
//       EX_memread with match(EXRd)) -> N=1. A non-load EX producer of a branch operand stalls 1.
//  FSM, two states, with a 2-bit rem counter:
//   IDLE: H2 -> stall this cycle (Mealy), rem<=1, next STALL; H1 -> stall this cycle, stay IDLE;
//         no hazard -> no stall.
//   STALL: stall asserted; hazard detection masked; rem==1 -> rem<=0, IDLE next.
//  Stall cycle: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0.
//  Forwarding applies only when beq|bnq and no stall. Priority is EX non-load 01, then MEM non-load 11,
//   then WB 10, then 00. The value is 00 in every stall cycle and for non-branch instructions.
//  Flush: ifid_flush=branch_taken & (beq|bnq) & ~stall & ~hold. PC still writes (target load).
//  Hold=1: all state and stall_cnt are frozen, with pc_write=ifid_write=0, idex_bubble=0 and ifid_flush=0.
//   forwardA/B keep their combinational value.
//  stall_cnt: +1 per cycle with idex_bubble=1; saturates and never wraps.
//  Reset mid-STALL: the FSM returns to IDLE next edge. Any pending stall is abandoned.
// TESTING
//  1 lw $5 in EX, beq $5,$6 in ID -> 2 stall cycles (cyc0 IDLE, cyc1 STALL), then forwardA=10, stall_cnt=2.
//  2 add $3 in EX, beq $3,$3 in ID -> 1 stall. Next cycle forwardA=forwardB=11, and taken gives ifid_flush=1.
//  3 lw $4 in EX, add $7,$4,$1 in ID -> one bubble, no forward output, then pc_write=1; EXRd=0 cases never stall.
//  4 hold=1 during STALL for 3 cycles -> state, rem and stall_cnt are unchanged, and stall resumes after hold drops.
//  5 rst_n=0 during STALL -> next cycle IDLE, pc_write=1, stall_cnt=0. With CNT_W=2, 5 stalls -> stall_cnt=3.

Source files
------------

// File: rtl/branch_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl_if
//   Groups the ID-stage hazard inputs and the pipeline control outputs of
//   branch_hazard_ctrl into one bundle.
//   slave  : the hazard controller (consumes pipeline state, drives enables)
//   master : the pipeline / stimulus side
//   Inputs : hold, beq, bnq, id_use_rs, id_use_rt, IDRs, IDRt, EXRd,
//            EX_regwrite, EX_memread, MEMRd, MEM_regwrite, MEM_memread,
//            WBRd, WB_regwrite, branch_taken
//   Outputs: pc_write, ifid_write, idex_bubble, ifid_flush, forwardA,
//            forwardB, stall_cnt[CNT_W-1:0]
// ---------------------------------------------------------------------------
interface branch_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             hold;
  logic             beq;
  logic             bnq;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       IDRs;
  logic [4:0]       IDRt;
  logic [4:0]       EXRd;
  logic             EX_regwrite;
  logic             EX_memread;
  logic [4:0]       MEMRd;
  logic             MEM_regwrite;
  logic             MEM_memread;
  logic [4:0]       WBRd;
  logic             WB_regwrite;
  logic             branch_taken;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic [1:0]       forwardA;
  logic [1:0]       forwardB;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  hold, beq, bnq, id_use_rs, id_use_rt, IDRs, IDRt,
           EXRd, EX_regwrite, EX_memread,
           MEMRd, MEM_regwrite, MEM_memread,
           WBRd, WB_regwrite, branch_taken,
    output pc_write, ifid_write, idex_bubble, ifid_flush,
           forwardA, forwardB, stall_cnt
  );

  modport master (
    output hold, beq, bnq, id_use_rs, id_use_rt, IDRs, IDRt,
           EXRd, EX_regwrite, EX_memread,
           MEMRd, MEM_regwrite, MEM_memread,
           WBRd, WB_regwrite, branch_taken,
    input  pc_write, ifid_write, idex_bubble, ifid_flush,
           forwardA, forwardB, stall_cnt
  );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
//   ID-stage hazard/stall sequencer for a 5-stage MIPS pipeline that resolves
//   branches in ID. Detects RAW hazards for branches and load-use, freezes
//   PC and IF/ID while inserting ID/EX bubbles, picks the forwarding source
//   for the ID comparator, flushes IF/ID on a taken branch and keeps a
//   saturating count of stall cycles.
//   Ports: clk   - pipeline clock
//          rst_n - synchronous active-low reset
//          bus   - branch_hazard_ctrl_if.slave (hazard inputs, controls out)
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | hazard detection live; may stall for one cycle (Mealy)
//   S_STALL | second cycle of a branch-after-load stall; detection masked
// ---------------------------------------------------------------------------
module branch_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_hazard_ctrl_if.slave bus
);

  typedef enum logic {S_IDLE = 1'b0, S_STALL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic branch;
  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
  logic ex_hit, mem_hit;
  logic haz2, haz1;
  logic stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  function automatic logic hit(input logic wr, input logic [4:0] rd,
                               input logic use_r, input logic [4:0] r);
    return wr && use_r && (rd != 5'd0) && (rd == r);
  endfunction

  // Nearest non-load producer wins; loads in EX/MEM never forward here
  // because they always stall first.
  function automatic logic [1:0] fwd_sel(input logic ex, input logic ex_ld,
                                         input logic mem, input logic mem_ld,
                                         input logic wb);
    if (ex && !ex_ld)        return 2'b01;
    else if (mem && !mem_ld) return 2'b11;
    else if (wb)             return 2'b10;
    else                     return 2'b00;
  endfunction

  assign branch = bus.beq | bus.bnq;

  assign ex_a  = hit(bus.EX_regwrite,  bus.EXRd,  bus.id_use_rs, bus.IDRs);
  assign ex_b  = hit(bus.EX_regwrite,  bus.EXRd,  bus.id_use_rt, bus.IDRt);
  assign mem_a = hit(bus.MEM_regwrite, bus.MEMRd, bus.id_use_rs, bus.IDRs);
  assign mem_b = hit(bus.MEM_regwrite, bus.MEMRd, bus.id_use_rt, bus.IDRt);
  assign wb_a  = hit(bus.WB_regwrite,  bus.WBRd,  bus.id_use_rs, bus.IDRs);
  assign wb_b  = hit(bus.WB_regwrite,  bus.WBRd,  bus.id_use_rt, bus.IDRt);

  assign ex_hit  = ex_a | ex_b;
  assign mem_hit = mem_a | mem_b;

  // Branch behind a load in EX needs the value two cycles later.
  assign haz2 = branch & bus.EX_memread & ex_hit;
  // Branch behind an ALU op in EX or a load in MEM, or ordinary load-use.
  assign haz1 = (branch & ((ex_hit & ~bus.EX_memread) | (bus.MEM_memread & mem_hit)))
              | (~branch & bus.EX_memread & ex_hit);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (haz2) begin
          stall   = 1'b1;
          state_d = S_STALL;
          rem_d   = 2'd1;
        end else if (haz1) begin
          stall = 1'b1;
        end
      end
      S_STALL: begin
        stall = 1'b1;
        if (rem_q <= 2'd1) begin
          rem_d   = 2'd0;
          state_d = S_IDLE;
        end else begin
          rem_d = rem_q - 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        rem_d   = 2'd0;
      end
    endcase
  end

  assign fwd_a_sel = (branch && !stall)
                   ? fwd_sel(ex_a, bus.EX_memread, mem_a, bus.MEM_memread, wb_a)
                   : 2'b00;
  assign fwd_b_sel = (branch && !stall)
                   ? fwd_sel(ex_b, bus.EX_memread, mem_b, bus.MEM_memread, wb_b)
                   : 2'b00;

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.idex_bubble = 1'b0;
    bus.ifid_flush  = 1'b0;
    bus.forwardA    = 2'b00;
    bus.forwardB    = 2'b00;
    if (!rst_n) begin
      // reset values are the defaults above
    end else if (bus.hold) begin
      bus.pc_write   = 1'b0;
      bus.ifid_write = 1'b0;
      bus.forwardA   = fwd_a_sel;
      bus.forwardB   = fwd_b_sel;
    end else if (stall) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
    end else begin
      // PC keeps writing on a taken branch so the target is loaded.
      bus.ifid_flush = bus.branch_taken & branch;
      bus.forwardA   = fwd_a_sel;
      bus.forwardB   = fwd_b_sel;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.idex_bubble && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= 2'd0;
      cnt_q   <= '0;
    end else if (!bus.hold) begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
module tb_branch_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_hazard_ctrl_if #(.CNT_W(16)) bus ();
  branch_hazard_ctrl_if #(.CNT_W(2))  bus2 ();

  branch_hazard_ctrl #(.CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  branch_hazard_ctrl #(.CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  // Second instance sees identical inputs; only its counter width differs.
  assign bus2.hold         = bus.hold;
  assign bus2.beq          = bus.beq;
  assign bus2.bnq          = bus.bnq;
  assign bus2.id_use_rs    = bus.id_use_rs;
  assign bus2.id_use_rt    = bus.id_use_rt;
  assign bus2.IDRs         = bus.IDRs;
  assign bus2.IDRt         = bus.IDRt;
  assign bus2.EXRd         = bus.EXRd;
  assign bus2.EX_regwrite  = bus.EX_regwrite;
  assign bus2.EX_memread   = bus.EX_memread;
  assign bus2.MEMRd        = bus.MEMRd;
  assign bus2.MEM_regwrite = bus.MEM_regwrite;
  assign bus2.MEM_memread  = bus.MEM_memread;
  assign bus2.WBRd         = bus.WBRd;
  assign bus2.WB_regwrite  = bus.WB_regwrite;
  assign bus2.branch_taken = bus.branch_taken;

  typedef struct {
    bit       rst_n, hold, beq, bnq, use_rs, use_rt;
    bit [4:0] rs, rt, exrd, memrd, wbrd;
    bit       exw, exl, memw, meml, wbw, taken;
  } stim_t;

  typedef struct {
    bit       pc, ifid, bub, fl;
    bit [1:0] fa, fb;
    int       cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: remaining forced stall cycles and bubble total.
  int   m_pending = 0;
  int   m_total   = 0;

  function automatic bit uses(bit wr, bit [4:0] rd, bit en, bit [4:0] r);
    return wr && en && rd != 0 && rd == r;
  endfunction

  // Cycles this operand must wait before its value is reachable from ID.
  function automatic int op_need(bit br, bit ex_m, bit ex_ld, bit mem_m, bit mem_ld);
    if (br) begin
      if (ex_m && ex_ld)   return 2;
      if (ex_m)            return 1;
      if (mem_m && mem_ld) return 1;
      return 0;
    end
    return (ex_m && ex_ld) ? 1 : 0;
  endfunction

  function automatic bit [1:0] op_src(bit ex_m, bit ex_ld, bit mem_m, bit mem_ld, bit wb_m);
    if (ex_m && !ex_ld)   return 2'b01;
    if (mem_m && !mem_ld) return 2'b11;
    if (wb_m)             return 2'b10;
    return 2'b00;
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s = '{default: 0};
    s.rst_n = 1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   br, stall;
    bit   exa, exb, mema, memb, wba, wbb;
    int   na, nb, n;
    @(posedge clk);
    #1;
    rst_n            = s.rst_n;
    bus.hold         = s.hold;
    bus.beq          = s.beq;
    bus.bnq          = s.bnq;
    bus.id_use_rs    = s.use_rs;
    bus.id_use_rt    = s.use_rt;
    bus.IDRs         = s.rs;
    bus.IDRt         = s.rt;
    bus.EXRd         = s.exrd;
    bus.EX_regwrite  = s.exw;
    bus.EX_memread   = s.exl;
    bus.MEMRd        = s.memrd;
    bus.MEM_regwrite = s.memw;
    bus.MEM_memread  = s.meml;
    bus.WBRd         = s.wbrd;
    bus.WB_regwrite  = s.wbw;
    bus.branch_taken = s.taken;

    br   = s.beq | s.bnq;
    exa  = uses(s.exw,  s.exrd,  s.use_rs, s.rs);
    exb  = uses(s.exw,  s.exrd,  s.use_rt, s.rt);
    mema = uses(s.memw, s.memrd, s.use_rs, s.rs);
    memb = uses(s.memw, s.memrd, s.use_rt, s.rt);
    wba  = uses(s.wbw,  s.wbrd,  s.use_rs, s.rs);
    wbb  = uses(s.wbw,  s.wbrd,  s.use_rt, s.rt);
    na   = op_need(br, exa, s.exl, mema, s.meml);
    nb   = op_need(br, exb, s.exl, memb, s.meml);
    n    = (na > nb) ? na : nb;
    stall = (m_pending > 0) || (n > 0);

    e.fa = (br && !stall) ? op_src(exa, s.exl, mema, s.meml, wba) : 2'b00;
    e.fb = (br && !stall) ? op_src(exb, s.exl, memb, s.meml, wbb) : 2'b00;
    e.cnt = m_total;
    if (!s.rst_n) begin
      e.pc = 1; e.ifid = 1; e.bub = 0; e.fl = 0; e.fa = 0; e.fb = 0;
    end else if (s.hold) begin
      e.pc = 0; e.ifid = 0; e.bub = 0; e.fl = 0;
    end else if (stall) begin
      e.pc = 0; e.ifid = 0; e.bub = 1; e.fl = 0;
    end else begin
      e.pc = 1; e.ifid = 1; e.bub = 0; e.fl = s.taken && br;
    end
    sbq.push_back(e);

    if (!s.rst_n) begin
      m_pending = 0;
      m_total   = 0;
    end else if (!s.hold) begin
      if (e.bub) m_total++;
      if (m_pending > 0)  m_pending--;
      else if (n == 2)    m_pending = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the queued response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pc_write",    32'(bus.pc_write),    32'(e.pc));
        chk("ifid_write",  32'(bus.ifid_write),  32'(e.ifid));
        chk("idex_bubble", 32'(bus.idex_bubble), 32'(e.bub));
        chk("ifid_flush",  32'(bus.ifid_flush),  32'(e.fl));
        chk("forwardA",    32'(bus.forwardA),    32'(e.fa));
        chk("forwardB",    32'(bus.forwardB),    32'(e.fb));
        chk("stall_cnt",   32'(bus.stall_cnt),   32'((e.cnt > 65535) ? 65535 : e.cnt));
        chk("stall_cnt_w2", 32'(bus2.stall_cnt), 32'((e.cnt > 3) ? 3 : e.cnt));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    rst_n            = 1'b0;
    bus.hold         = 1'b0;
    bus.beq          = 1'b0;
    bus.bnq          = 1'b0;
    bus.id_use_rs    = 1'b0;
    bus.id_use_rt    = 1'b0;
    bus.IDRs         = '0;
    bus.IDRt         = '0;
    bus.EXRd         = '0;
    bus.EX_regwrite  = 1'b0;
    bus.EX_memread   = 1'b0;
    bus.MEMRd        = '0;
    bus.MEM_regwrite = 1'b0;
    bus.MEM_memread  = 1'b0;
    bus.WBRd         = '0;
    bus.WB_regwrite  = 1'b0;
    bus.branch_taken = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held, with a hazard present: outputs must still be reset values.
    s = nop(); s.rst_n = 0; s.beq = 1; s.use_rs = 1; s.rs = 5;
    s.exrd = 5; s.exw = 1; s.exl = 1;
    apply(s);

    // lw $5 in EX, beq $5,$6: two stalls, then WB forward on rs.
    s = nop(); s.beq = 1; s.use_rs = 1; s.use_rt = 1; s.rs = 5; s.rt = 6;
    s.exrd = 5; s.exw = 1; s.exl = 1;
    apply(s);
    apply(s);
    s = nop(); s.beq = 1; s.use_rs = 1; s.use_rt = 1; s.rs = 5; s.rt = 6;
    s.wbrd = 5; s.wbw = 1;
    apply(s);

    // add $3 in EX, beq $3,$3 taken: one stall, then MEM forward both and flush.
    s = nop(); s.beq = 1; s.use_rs = 1; s.use_rt = 1; s.rs = 3; s.rt = 3;
    s.exrd = 3; s.exw = 1; s.taken = 1;
    apply(s);
    s.exrd = 0; s.exw = 0; s.memrd = 3; s.memw = 1;
    apply(s);

    // lw $4 in EX, add $7,$4,$1: one bubble, then free-running.
    s = nop(); s.use_rs = 1; s.use_rt = 1; s.rs = 4; s.rt = 1;
    s.exrd = 4; s.exw = 1; s.exl = 1;
    apply(s);
    s.exrd = 0; s.exw = 0; s.exl = 0;
    apply(s);
    // Destination $0 never stalls.
    s = nop(); s.bnq = 1; s.use_rs = 1; s.use_rt = 1;
    s.exrd = 0; s.exw = 1; s.exl = 1;
    apply(s);

    // Hold for three cycles inside STALL, then the stall resumes.
    s = nop(); s.bnq = 1; s.use_rt = 1; s.rt = 9;
    s.exrd = 9; s.exw = 1; s.exl = 1;
    apply(s);
    s = nop(); s.hold = 1;
    repeat (3) apply(s);
    s.hold = 0;
    apply(s);
    apply(s);

    // Reset during STALL abandons the pending stall.
    s = nop(); s.beq = 1; s.use_rs = 1; s.rs = 2;
    s.exrd = 2; s.exw = 1; s.exl = 1;
    apply(s);
    s = nop(); s.rst_n = 0;
    apply(s);
    s = nop();
    apply(s);

    // Five consecutive load-use stalls saturate the 2-bit counter.
    s = nop(); s.use_rs = 1; s.rs = 7; s.exrd = 7; s.exw = 1; s.exl = 1;
    repeat (5) apply(s);
    s = nop();
    apply(s);

    for (int i = 0; i < 3000; i++) begin
      s.rst_n  = ($urandom % 64) != 0;
      s.hold   = ($urandom % 8) == 0;
      s.beq    = ($urandom % 3) == 0;
      s.bnq    = ($urandom % 5) == 0;
      s.use_rs = ($urandom % 4) != 0;
      s.use_rt = ($urandom % 4) != 0;
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.exrd   = 5'($urandom_range(0, 3));
      s.memrd  = 5'($urandom_range(0, 3));
      s.wbrd   = 5'($urandom_range(0, 3));
      s.exw    = 1'($urandom);
      s.exl    = 1'($urandom);
      s.memw   = 1'($urandom);
      s.meml   = 1'($urandom);
      s.wbw    = 1'($urandom);
      s.taken  = 1'($urandom);
      apply(s);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
